// File: rtl/ram_bus_responder.sv
// ram_bus_responder: V810 bus-side RAM slave. Turns each CPU RAM cycle
// (BCYSTn/CEn sampled on CE) into one level req / pulse ack transaction on the
// memory port and paces READYn wait states on the bus side.
// Optional feature macro: RAMBR_POSTED_WR_EN (posted writes with DRAIN state).
module ram_bus_responder #(
    parameter int unsigned MIN_WAIT = 1,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce_i,
    input  logic        bcyst_n_i,
    input  logic        ce_n_i,
    input  logic        we_n_i,
    input  logic [3:0]  be_n_i,
    input  logic [20:0] a_i,
    input  logic [31:0] di_i,
    output logic [31:0] do_o,
    output logic        ready_n_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [18:0] mem_a_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        err_o
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

`ifdef RAMBR_POSTED_WR_EN
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_READY, S_DRAIN} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_READY} state_e;
`endif

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ready_n_q, ready_n_d;
    logic [DATA_W-1:0]   do_q, do_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                err_q, err_d;
    logic                ack_seen_q, ack_seen_d;
    logic                abort_q, abort_d;
`ifdef RAMBR_POSTED_WR_EN
    logic                pend_we_q, pend_we_d;
    logic [ADDR_W-1:0]   pend_a_q, pend_a_d;
    logic [BE_W-1:0]     pend_be_q, pend_be_d;
    logic [DATA_W-1:0]   pend_wdata_q, pend_wdata_d;
`endif

    logic                start_c;
    logic                ack_c;
    logic                to_c;
    logic                min_ok_c;
    logic [CNT_W-1:0]    cnt_inc_c;
    logic [CNT_W-1:0]    cnt_eff_c;
    logic                abort_now_c;
    logic                abort_any_c;
    logic                done_c;
    logic                issue_c;
    logic                iss_we_c;
    logic [ADDR_W-1:0]   iss_a_c;
    logic [BE_W-1:0]     iss_be_c;
    logic [DATA_W-1:0]   iss_wdata_c;
    logic                unused_c;

    // Byte-lane address bits carry no information for a word-wide memory.
    assign unused_c = ^a_i[1:0];

    // Shared qualifiers: cycle start, accepted ack, wait counter view, timeout.
    always_comb begin
        start_c     = ce_i & ~bcyst_n_i & ~ce_n_i;
        ack_c       = mem_req_q & mem_ack_i;
        cnt_inc_c   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        cnt_eff_c   = ce_i ? cnt_inc_c : cnt_q;
        min_ok_c    = (32'(cnt_eff_c) >= MIN_WAIT);
        to_c        = (TIMEOUT != 0) && ce_i && mem_req_q && !mem_ack_i
                      && (32'(cnt_inc_c) == TIMEOUT);
        abort_now_c = ce_i & ce_n_i;
        abort_any_c = abort_q | abort_now_c;
        done_c      = ack_c | ack_seen_q;
    end

    // Next-state and datapath updates for the bus/memory handshake.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_eff_c;
        ready_n_d   = ready_n_q;
        do_d        = do_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_a_d     = mem_a_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = 1'b0;
        ack_seen_d  = ack_seen_q | ack_c;
        abort_d     = abort_q;
        issue_c     = 1'b0;
        iss_we_c    = ~we_n_i;
        iss_a_c     = a_i[20:2];
        iss_be_c    = ~be_n_i;
        iss_wdata_c = di_i;
`ifdef RAMBR_POSTED_WR_EN
        pend_we_d    = pend_we_q;
        pend_a_d     = pend_a_q;
        pend_be_d    = pend_be_q;
        pend_wdata_d = pend_wdata_q;
`endif

        // The memory request drops on ack or forced completion, in any state.
        if (ack_c) begin
            mem_req_d = 1'b0;
        end
        if (to_c) begin
            mem_req_d = 1'b0;
            err_d     = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_c) begin
`ifdef RAMBR_POSTED_WR_EN
                    if (mem_req_q && !ack_c) begin
                        pend_we_d    = iss_we_c;
                        pend_a_d     = iss_a_c;
                        pend_be_d    = iss_be_c;
                        pend_wdata_d = iss_wdata_c;
                        state_d      = S_DRAIN;
                    end else begin
                        issue_c = 1'b1;
                    end
`else
                    issue_c = 1'b1;
`endif
                end
            end
            S_REQ: begin
                if (abort_now_c) begin
                    abort_d = 1'b1;
                end
                if (ack_c && !mem_we_q && !abort_any_c) begin
                    do_d = mem_rdata_i;
                end
                if (to_c) begin
                    if (!mem_we_q && !abort_any_c) begin
                        do_d = {DATA_W{1'b1}};
                    end
                    state_d = abort_any_c ? S_IDLE : S_READY;
                end else if (done_c && abort_any_c) begin
                    state_d = S_IDLE;
                end else if (done_c && min_ok_c) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (ce_i) begin
                    if (ready_n_q) begin
                        if (min_ok_c) begin
                            ready_n_d = 1'b0;
                        end
                    end else begin
                        ready_n_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
`ifdef RAMBR_POSTED_WR_EN
            S_DRAIN: begin
                if (!mem_req_q || ack_c) begin
                    issue_c     = 1'b1;
                    iss_we_c    = pend_we_q;
                    iss_a_c     = pend_a_q;
                    iss_be_c    = pend_be_q;
                    iss_wdata_c = pend_wdata_q;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Launch a new memory access; reads always fetch the whole word.
        if (issue_c) begin
            mem_req_d   = 1'b1;
            mem_we_d    = iss_we_c;
            mem_a_d     = iss_a_c;
            mem_be_d    = iss_we_c ? iss_be_c : {BE_W{1'b1}};
            mem_wdata_d = iss_wdata_c;
            cnt_d       = '0;
            ack_seen_d  = 1'b0;
            abort_d     = 1'b0;
`ifdef RAMBR_POSTED_WR_EN
            state_d     = iss_we_c ? S_READY : S_REQ;
`else
            state_d     = S_REQ;
`endif
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ready_n_q    <= 1'b1;
            do_q         <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_a_q      <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            err_q        <= 1'b0;
            ack_seen_q   <= 1'b0;
            abort_q      <= 1'b0;
`ifdef RAMBR_POSTED_WR_EN
            pend_we_q    <= 1'b0;
            pend_a_q     <= '0;
            pend_be_q    <= '0;
            pend_wdata_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ready_n_q    <= ready_n_d;
            do_q         <= do_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_a_q      <= mem_a_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            err_q        <= err_d;
            ack_seen_q   <= ack_seen_d;
            abort_q      <= abort_d;
`ifdef RAMBR_POSTED_WR_EN
            pend_we_q    <= pend_we_d;
            pend_a_q     <= pend_a_d;
            pend_be_q    <= pend_be_d;
            pend_wdata_q <= pend_wdata_d;
`endif
        end
    end

    assign do_o        = do_q;
    assign ready_n_o   = ready_n_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_a_o     = mem_a_q;
    assign mem_be_o    = mem_be_q;
    assign mem_wdata_o = mem_wdata_q;
    assign err_o       = err_q;

endmodule
